btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 78 +++++++
 tb/tb_btn_debounce.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with per-channel press/release pulses,
// sticky press-pending flags and a registered, maskable interrupt request.
module btn_debounce #(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic               core_clk,
   input  logic               core_rst,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic [NUM_BTN-1:0] clr_i,
   input  logic [NUM_BTN-1:0] irq_en_i,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] press_o,
   output logic [NUM_BTN-1:0] release_o,
   output logic [NUM_BTN-1:0] pend_o,
   output logic               irq_o
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0] IDLE_PIN = ACTIVE_LOW ? '1 : '0;

   logic [NUM_BTN-1:0] sync1_q;
   logic [NUM_BTN-1:0] sync2_q;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] toggle;
   logic [CW-1:0]      cnt_q [NUM_BTN];

   // Synchronizers reset to the released pin level so reset never looks like a press.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         sync1_q <= IDLE_PIN;
         sync2_q <= IDLE_PIN;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   assign level = ACTIVE_LOW ? ~sync2_q : sync2_q;

   // A channel flips when this differing sample would complete the stable run.
   always_comb begin
      toggle = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         toggle[i] = (level[i] != btn_o[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt_q[i] <= '0;
         end
         btn_o     <= '0;
         press_o   <= '0;
         release_o <= '0;
         pend_o    <= '0;
         irq_o     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if ((level[i] == btn_o[i]) || toggle[i]) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
         btn_o     <= btn_o ^ toggle;
         press_o   <= toggle & ~btn_o;
         release_o <= toggle & btn_o;
         // Pending is set from the registered press pulse, so a clear in that cycle loses.
         pend_o    <= (pend_o & ~clr_i) | press_o;
         irq_o     <= |(pend_o & irq_en_i);
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios followed by random
// pin activity, compared against a sample-window reference model.
module tb_btn_debounce;

   localparam int NB = 5;
   localparam int DB = 4;

   logic          core_clk = 1'b0;
   logic          core_rst;
   logic [NB-1:0] btn_i;
   logic [NB-1:0] clr_i;
   logic [NB-1:0] irq_en_i;
   logic [NB-1:0] btn_o;
   logic [NB-1:0] press_o;
   logic [NB-1:0] release_o;
   logic [NB-1:0] pend_o;
   logic          irq_o;

   logic [NB-1:0] m_btn, m_press, m_rel, m_pend;
   logic          m_irq;
   logic [NB-1:0] hist[$];
   int            last_event [NB];
   int            errors = 0;
   int            checks = 0;

   logic [NB-1:0] cur_btn, cur_clr, cur_en;

   btn_debounce #(
      .NUM_BTN(NB),
      .DEBOUNCE_CYCLES(DB),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .core_clk (core_clk),
      .core_rst (core_rst),
      .btn_i    (btn_i),
      .clr_i    (clr_i),
      .irq_en_i (irq_en_i),
      .btn_o    (btn_o),
      .press_o  (press_o),
      .release_o(release_o),
      .pend_o   (pend_o),
      .irq_o    (irq_o)
   );

   always #5 core_clk = ~core_clk;

   // A channel settles when the last DB synchronized samples (pin two edges back)
   // all disagree with the debounced level and none predate the last flip/reset.
   function automatic logic settled(int ch, int n);
      if (n - last_event[ch] < DB) return 1'b0;
      for (int j = 0; j < DB; j++) begin
         if (n - 2 - j < 0) return 1'b0;
         if (hist[n-2-j][ch] == m_btn[ch]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic modelEdge();
      int            n;
      logic [NB-1:0] tog;
      tog = '0;
      if (core_rst) begin
         hist.push_back('0);
         n = hist.size() - 1;
         m_btn = '0; m_press = '0; m_rel = '0; m_pend = '0; m_irq = 1'b0;
         for (int c = 0; c < NB; c++) last_event[c] = n;
      end else begin
         hist.push_back(~btn_i);
         n = hist.size() - 1;
         m_irq  = |(m_pend & irq_en_i);
         m_pend = (m_pend & ~clr_i) | m_press;
         for (int c = 0; c < NB; c++) tog[c] = settled(c, n);
         m_press = tog & ~m_btn;
         m_rel   = tog & m_btn;
         m_btn   = m_btn ^ tog;
         for (int c = 0; c < NB; c++) if (tog[c]) last_event[c] = n;
      end
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      assert (btn_o === m_btn) else begin
         errors++;
         $error("[TB] FAIL %s btn_o observed=%b expected=%b", tag, btn_o, m_btn);
      end
      checks++;
      assert (press_o === m_press) else begin
         errors++;
         $error("[TB] FAIL %s press_o observed=%b expected=%b", tag, press_o, m_press);
      end
      checks++;
      assert (release_o === m_rel) else begin
         errors++;
         $error("[TB] FAIL %s release_o observed=%b expected=%b", tag, release_o, m_rel);
      end
      checks++;
      assert (pend_o === m_pend) else begin
         errors++;
         $error("[TB] FAIL %s pend_o observed=%b expected=%b", tag, pend_o, m_pend);
      end
      checks++;
      assert (irq_o === m_irq) else begin
         errors++;
         $error("[TB] FAIL %s irq_o observed=%b expected=%b", tag, irq_o, m_irq);
      end
   endtask

   task automatic applyStimulus(input logic rst, input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) begin
         core_rst = rst;
         btn_i    = cur_btn;
         clr_i    = cur_clr;
         irq_en_i = cur_en;
         @(posedge core_clk);
         modelEdge();
         #1;
         checkOutput(tag);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   initial begin
      cur_btn = '1; cur_clr = '0; cur_en = '0;
      $display("[TB] reset and idle");
      applyStimulus(1'b1, 3, "reset");
      applyStimulus(1'b0, 20, "idle");

      $display("[TB] channel 0 press");
      cur_en = '1;
      cur_btn[0] = 1'b0;
      applyStimulus(1'b0, 5, "press0_wait");
      checkBit("press0_early", press_o[0], 1'b0);
      applyStimulus(1'b0, 1, "press0_edge");
      checkBit("press0_edge6", press_o[0], 1'b1);
      checkBit("btn0_edge6", btn_o[0], 1'b1);
      applyStimulus(1'b0, 4, "press0_hold");
      checkBit("irq_after_press0", irq_o, 1'b1);

      $display("[TB] channel 1 glitch");
      cur_btn[1] = 1'b0;
      applyStimulus(1'b0, 3, "glitch1");
      cur_btn[1] = 1'b1;
      applyStimulus(1'b0, 10, "glitch1_after");
      checkBit("glitch1_pend", pend_o[1], 1'b0);

      $display("[TB] channel 0 release and clear");
      cur_btn[0] = 1'b1;
      applyStimulus(1'b0, 6, "release0");
      checkBit("release0_edge6", release_o[0], 1'b1);
      checkBit("pend0_kept", pend_o[0], 1'b1);
      applyStimulus(1'b0, 3, "release0_hold");
      cur_clr[0] = 1'b1;
      applyStimulus(1'b0, 1, "clr0");
      cur_clr[0] = 1'b0;
      applyStimulus(1'b0, 3, "clr0_after");
      checkBit("pend0_cleared", pend_o[0], 1'b0);
      checkBit("irq_cleared", irq_o, 1'b0);

      $display("[TB] channel 2 set beats clear");
      cur_btn[2] = 1'b0;
      applyStimulus(1'b0, 6, "press2");
      checkBit("press2_edge6", press_o[2], 1'b1);
      cur_clr[2] = 1'b1;
      applyStimulus(1'b0, 1, "press2_clr");
      cur_clr[2] = 1'b0;
      applyStimulus(1'b0, 2, "press2_after");
      checkBit("pend2_set_wins", pend_o[2], 1'b1);

      $display("[TB] channel 3 reset mid-count");
      cur_btn[3] = 1'b0;
      applyStimulus(1'b0, 5, "press3_partial");
      applyStimulus(1'b1, 3, "press3_reset");
      applyStimulus(1'b0, 5, "press3_post");
      checkBit("press3_early", press_o[3], 1'b0);
      applyStimulus(1'b0, 1, "press3_edge");
      checkBit("press3_edge6", press_o[3], 1'b1);
      applyStimulus(1'b0, 4, "press3_hold");

      $display("[TB] random activity");
      for (int it = 0; it < 1500; it++) begin
         for (int c = 0; c < NB; c++) begin
            if ($urandom_range(9) == 0) cur_btn[c] = ~cur_btn[c];
         end
         cur_clr = NB'($urandom & $urandom & $urandom);
         if ($urandom_range(49) == 0) cur_en = NB'($urandom);
         if ($urandom_range(199) == 0) begin
            applyStimulus(1'b1, int'($urandom_range(3, 2)), "rand_reset");
         end else begin
            applyStimulus(1'b0, 1, "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
